// File: rtl/ssd1306_power_seq_if.sv
// ssd1306_power_seq_if: request/status, panel pins, command-engine and timer handshakes of the power sequencer
interface ssd1306_power_seq_if;
    logic        power_up;
    logic        power_down;
    logic        busy;
    logic        is_on;
    logic        vdd_n;
    logic        vbat_n;
    logic        res_n;
    logic        init_start;
    logic        init_done;
    logic        dispoff_start;
    logic        dispoff_done;
    logic [12:0] tmr_timeout_ms;
    logic        tmr_enable;
    logic        tmr_timedout;

    modport slave (
        input  power_up, power_down, init_done, dispoff_done, tmr_timedout,
        output busy, is_on, vdd_n, vbat_n, res_n, init_start, dispoff_start,
               tmr_timeout_ms, tmr_enable
    );

    modport master (
        output power_up, power_down, init_done, dispoff_done, tmr_timedout,
        input  busy, is_on, vdd_n, vbat_n, res_n, init_start, dispoff_start,
               tmr_timeout_ms, tmr_enable
    );
endinterface

// File: rtl/ssd1306_power_seq.sv
// ssd1306_power_seq: SSD1306 rail/RES# power sequencer; every delay is an ARM cycle then a RUN phase on the shared ms timer
module ssd1306_power_seq #(
    parameter int VDD_SETTLE_MS  = 1,
    parameter int RES_LOW_MS     = 1,
    parameter int RES_RECOVER_MS = 1,
    parameter int VBAT_SETTLE_MS = 100
) (
    input logic                clk,
    input logic                resetn,
    ssd1306_power_seq_if.slave ps
);
    localparam logic [3:0] OFF      = 4'd0;
    localparam logic [3:0] VDD_ON   = 4'd1;
    localparam logic [3:0] RES_LOW  = 4'd2;
    localparam logic [3:0] RES_REL  = 4'd3;
    localparam logic [3:0] INIT     = 4'd4;
    localparam logic [3:0] VBAT_ON  = 4'd5;
    localparam logic [3:0] ON       = 4'd6;
    localparam logic [3:0] DOFF     = 4'd7;
    localparam logic [3:0] VBAT_OFF = 4'd8;
    localparam logic [3:0] VDD_OFF  = 4'd9;

    // A 0 ms limit makes the timer expire at once, so the delays would silently vanish
    if (VDD_SETTLE_MS < 1 || RES_LOW_MS < 1 || RES_RECOVER_MS < 1 || VBAT_SETTLE_MS < 1 ||
        VDD_SETTLE_MS > 1000 || RES_LOW_MS > 1000 || RES_RECOVER_MS > 1000 || VBAT_SETTLE_MS > 1000) begin : g_bad_param
        $error("ssd1306_power_seq: delay parameters must be 1..1000 ms");
    end

    logic [3:0]  state, nxt_state;
    logic        run, nxt_run;
    logic [12:0] nxt_timeout;

    // run=0 is the ARM cycle of a delay state or the start-pulse cycle of a handoff state
    always_comb begin
        nxt_state = state;
        nxt_run   = run;
        case (state)
            OFF:     if (ps.power_up) nxt_state = VDD_ON;
            ON:      if (ps.power_down) nxt_state = DOFF;
            VDD_OFF: nxt_state = OFF;
            INIT: begin
                nxt_run = 1'b1;
                if (run && ps.init_done) {nxt_state, nxt_run} = {VBAT_ON, 1'b0};
            end
            DOFF: begin
                nxt_run = 1'b1;
                if (run && ps.dispoff_done) {nxt_state, nxt_run} = {VBAT_OFF, 1'b0};
            end
            VDD_ON, RES_LOW, RES_REL, VBAT_ON, VBAT_OFF: begin
                nxt_run = 1'b1;
                if (run && ps.tmr_timedout) begin
                    nxt_run   = 1'b0;
                    nxt_state = state == VDD_ON  ? RES_LOW :
                                state == RES_LOW ? RES_REL :
                                state == RES_REL ? INIT    :
                                state == VBAT_ON ? ON      : VDD_OFF;
                end
            end
            default: {nxt_state, nxt_run} = {OFF, 1'b0};
        endcase
    end

    always_comb
        nxt_timeout = nxt_state == VDD_ON                           ? 13'(VDD_SETTLE_MS)  :
                      nxt_state == RES_LOW                          ? 13'(RES_LOW_MS)     :
                      nxt_state == RES_REL                          ? 13'(RES_RECOVER_MS) :
                      nxt_state == VBAT_ON || nxt_state == VBAT_OFF ? 13'(VBAT_SETTLE_MS) : 13'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= OFF;
            run               <= 1'b0;
            ps.busy           <= 1'b0;
            ps.is_on          <= 1'b0;
            ps.vdd_n          <= 1'b1;
            ps.vbat_n         <= 1'b1;
            ps.res_n          <= 1'b1;
            ps.init_start     <= 1'b0;
            ps.dispoff_start  <= 1'b0;
            ps.tmr_timeout_ms <= 13'd0;
            ps.tmr_enable     <= 1'b0;
        end else begin
            state             <= nxt_state;
            run               <= nxt_run;
            ps.busy           <= nxt_state != OFF && nxt_state != ON;
            ps.is_on          <= nxt_state == ON;
            ps.vdd_n          <= nxt_state == OFF || nxt_state == VDD_OFF;
            ps.vbat_n         <= !(nxt_state inside {VBAT_ON, ON, DOFF});
            ps.res_n          <= nxt_state != RES_LOW;
            ps.init_start     <= nxt_state == INIT && !nxt_run;
            ps.dispoff_start  <= nxt_state == DOFF && !nxt_run;
            ps.tmr_timeout_ms <= nxt_timeout;
            ps.tmr_enable     <= nxt_run && nxt_timeout != 13'd0;
        end
    end
endmodule

// File: tb/tb_ssd1306_power_seq.sv
// tb_ssd1306_power_seq: table-driven cycle-exact check of the power sequencer against a 10-cycle/ms timer
// and a command engine answering 5 cycles after each start pulse.
module tb_ssd1306_power_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ssd1306_power_seq_if ps();

    ssd1306_power_seq #(.VBAT_SETTLE_MS(3)) dut (
        .clk   (clk),
        .resetn(resetn),
        .ps    (ps)
    );

    int tests = 0;
    int failed = 0;
    int mon_err = 0;

    // ms timer: limit latched one cycle late, 10 clocks per ms, cleared while enable is low
    logic [12:0] lim = 13'd0;
    int          tcyc = 0;
    int          tms = 0;
    logic        tmr_to = 1'b0;
    always @(posedge clk) begin
        lim <= ps.tmr_timeout_ms;
        if (!ps.tmr_enable) begin
            tcyc   <= 0;
            tms    <= 0;
            tmr_to <= 1'b0;
        end else if (tcyc == 9) begin
            tcyc <= 0;
            tms  <= tms + 1;
            if (tms + 1 >= int'(lim)) tmr_to <= 1'b1;
        end else tcyc <= tcyc + 1;
    end
    assign ps.tmr_timedout = tmr_to;

    // command engine: one-cycle done pulse 5 cycles after a start, or manual drive
    logic auto_eng = 1'b1;
    logic man_init = 1'b0;
    logic man_doff = 1'b0;
    logic eng_init = 1'b0;
    logic eng_doff = 1'b0;
    int   icnt = 0;
    int   dcnt = 0;
    always @(posedge clk) begin
        eng_init <= 1'b0;
        eng_doff <= 1'b0;
        if (auto_eng && ps.init_start) icnt <= 5;
        else if (icnt != 0) begin
            icnt <= icnt - 1;
            if (icnt == 1) eng_init <= 1'b1;
        end
        if (auto_eng && ps.dispoff_start) dcnt <= 5;
        else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) eng_doff <= 1'b1;
        end
    end
    assign ps.init_done = eng_init | man_init;
    assign ps.dispoff_done = eng_doff | man_doff;

    // whole-run protocol monitor
    logic [12:0] p_tmo = 13'd0;
    logic [2:0]  p_rails = 3'b111;
    logic        p_en = 1'b0;
    logic        p_is = 1'b0;
    logic        p_ds = 1'b0;
    always @(negedge clk) begin
        if (!ps.vbat_n && (ps.vdd_n || !ps.res_n)) begin
            mon_err <= mon_err + 1;
            $display("FAIL rail_order at %0t: vdd_n=%b vbat_n=%b res_n=%b", $time, ps.vdd_n, ps.vbat_n, ps.res_n);
        end
        if (ps.tmr_enable && (ps.tmr_timeout_ms != p_tmo || ps.tmr_timeout_ms == 13'd0)) begin
            mon_err <= mon_err + 1;
            $display("FAIL tmr_timeout_stable at %0t: got %0d previous %0d", $time, ps.tmr_timeout_ms, p_tmo);
        end
        if (ps.tmr_enable && p_en && {ps.vdd_n, ps.vbat_n, ps.res_n} != p_rails) begin
            mon_err <= mon_err + 1;
            $display("FAIL tmr_enable_gap at %0t: enable stayed high across a delay change", $time);
        end
        if ((ps.init_start && p_is) || (ps.dispoff_start && p_ds)) begin
            mon_err <= mon_err + 1;
            $display("FAIL start_pulse_width at %0t: start high 2 cycles", $time);
        end
        p_tmo   <= ps.tmr_timeout_ms;
        p_rails <= {ps.vdd_n, ps.vbat_n, ps.res_n};
        p_en    <= ps.tmr_enable;
        p_is    <= ps.init_start;
        p_ds    <= ps.dispoff_start;
    end

    typedef struct {
        logic        pu;
        logic        pd;
        int          adv;
        logic [7:0]  f;
        logic [12:0] tmo;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic pu, input logic pd, input int adv, input logic [7:0] f, input logic [12:0] tmo);
        vec_t r;
        r.pu = pu; r.pd = pd; r.adv = adv; r.f = f; r.tmo = tmo;
        vecs.push_back(r);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // {busy, is_on, vdd_n, vbat_n, res_n, init_start, dispoff_start, tmr_enable}
    function automatic logic [7:0] flags();
        return {ps.busy, ps.is_on, ps.vdd_n, ps.vbat_n, ps.res_n, ps.init_start, ps.dispoff_start, ps.tmr_enable};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        add(1, 0,  1, 8'b1001_1000, 13'd1);  // VDD_ON arm
        add(0, 0,  1, 8'b1001_1001, 13'd1);  // VDD_ON run
        add(0, 0, 10, 8'b1001_1001, 13'd1);  // last VDD_ON cycle
        add(0, 0,  1, 8'b1001_0000, 13'd1);  // RES_LOW arm
        add(0, 0, 11, 8'b1001_0001, 13'd1);  // last RES_LOW cycle
        add(0, 0,  1, 8'b1001_1000, 13'd1);  // RES_REL arm
        add(0, 0, 12, 8'b1001_1100, 13'd0);  // INIT start pulse
        add(0, 0,  1, 8'b1001_1000, 13'd0);  // INIT wait
        add(0, 0,  6, 8'b1000_1000, 13'd3);  // VBAT_ON arm
        add(0, 0,  1, 8'b1000_1001, 13'd3);  // VBAT_ON run
        add(0, 0, 30, 8'b1000_1001, 13'd3);  // last VBAT_ON cycle
        add(0, 0,  1, 8'b0100_1000, 13'd0);  // ON
        add(0, 1,  1, 8'b1000_1010, 13'd0);  // DOFF start pulse
        add(0, 0,  1, 8'b1000_1000, 13'd0);  // DOFF wait
        add(0, 0,  6, 8'b1001_1000, 13'd3);  // VBAT_OFF arm
        add(0, 0, 32, 8'b1011_1000, 13'd0);  // VDD_OFF
        add(0, 0,  1, 8'b0011_1000, 13'd0);  // OFF
        add(0, 1,  1, 8'b0011_1000, 13'd0);  // power_down ignored in OFF
        add(1, 1,  1, 8'b1001_1000, 13'd1);  // both in OFF: power_up wins
        add(1, 0, 12, 8'b1001_0000, 13'd1);  // power_up ignored in VDD_ON
        add(1, 0,  1, 8'b1001_0001, 13'd1);  // power_up ignored in RES_LOW
        add(0, 0, 11, 8'b1001_1000, 13'd1);  // RES_REL arm
        add(0, 0, 12, 8'b1001_1100, 13'd0);  // INIT start pulse
        add(0, 0,  7, 8'b1000_1000, 13'd3);  // VBAT_ON arm
        add(1, 1,  1, 8'b1000_1001, 13'd3);  // both ignored in VBAT_ON
        add(0, 0, 30, 8'b1000_1001, 13'd3);  // last VBAT_ON cycle
        add(0, 0,  1, 8'b0100_1000, 13'd0);  // ON
        add(1, 0,  1, 8'b0100_1000, 13'd0);  // power_up ignored in ON

        ps.power_up = 1'b0;
        ps.power_down = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", 32'(flags()), 32'h38);
        check("reset_tmo", 32'(ps.tmr_timeout_ms), 0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            ps.power_up = vecs[i].pu;
            ps.power_down = vecs[i].pd;
            @(negedge clk);
            ps.power_up = 1'b0;
            ps.power_down = 1'b0;
            repeat (vecs[i].adv - 1) @(negedge clk);
            check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].f));
            check($sformatf("vec%0d_tmo", i), 32'(ps.tmr_timeout_ms), 32'(vecs[i].tmo));
        end

        // reset from ON
        resetn = 1'b0;
        @(negedge clk);
        check("reset_from_on", 32'(flags()), 32'h38);
        resetn = 1'b1;

        // reset in the middle of the VBAT_ON delay
        ps.power_up = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        ps.power_up = 1'b0;
        while (ps.vbat_n && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("vbat_on_latency", n, 44);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("reset_mid_flags", 32'(flags()), 32'h38);
        check("reset_mid_tmo", 32'(ps.tmr_timeout_ms), 0);
        resetn = 1'b1;
        ps.power_up = 1'b1;
        n = 0;
        @(negedge clk);
        n++;
        ps.power_up = 1'b0;
        while (!ps.is_on && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("full_seq_len", n, 76);

        // done already high during the start pulse must be ignored
        auto_eng = 1'b0;
        ps.power_down = 1'b1;
        @(negedge clk);
        ps.power_down = 1'b0;
        check("dc_start", 32'(ps.dispoff_start), 1);
        man_doff = 1'b1;
        @(negedge clk);
        man_doff = 1'b0;
        repeat (10) @(negedge clk);
        check("dc_ignored", 32'(flags()), 32'h88);
        man_doff = 1'b1;
        @(negedge clk);
        man_doff = 1'b0;
        check("dc_accept", 32'(flags()), 32'h98);
        check("dc_accept_tmo", 32'(ps.tmr_timeout_ms), 3);
        auto_eng = 1'b1;
        n = 0;
        while (ps.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("dc_to_off", n, 33);
        check("dc_off_flags", 32'(flags()), 32'h38);

        @(negedge clk);
        check("monitor", mon_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
